membus_arbiter: RTL and testbench
=================================

# membus_arbiter

Parametrised two-master memory arbiter that merges the CPU's iBus and dBus command streams onto one single-port memory bus. It tracks outstanding reads in an in-order tag FIFO and routes each response back to the issuing bus. Write byte masks and read-data lane extraction are derived from access size and address. It sits between the CPU core and a single-ported memory, and generalises the fixed one-interface, dBus-only, zero-outstanding hookup to selectable arbitration and pipelined reads.

## Interface
Parameters:
- ADDR_W, 32, address width of all buses
- MAX_PENDING, 4, outstanding-read FIFO depth; power of 2, at least 2
- PRIO_MODE, 0, 0 = round-robin, 1 = dBus fixed priority

Ports:
- clk_cpu  in  1  sole clock, rising edge
- clk_cpu_reset_  in  1  asynchronous active-low reset
- iBus_cmd_valid / iBus_cmd_ready  in / out  1  instruction fetch handshake
- iBus_cmd_payload_pc  in  ADDR_W  fetch address; fetches are always word reads
- iBus_rsp_valid  out  1  fetch response strobe
- iBus_rsp_payload_error  out  1  copy of mem_rsp_error
- iBus_rsp_payload_inst  out  32  fetched word
- dBus_cmd_valid / dBus_cmd_ready  in / out  1  data access handshake
- dBus_cmd_payload_wr  in  1  1 = write
- dBus_cmd_payload_address  in  ADDR_W  byte address
- dBus_cmd_payload_data  in  32  write data, low-aligned
- dBus_cmd_payload_size  in  2  00 = byte, 01 = half, 10/11 = word
- dBus_rsp_ready  out  1  read response strobe
- dBus_rsp_error  out  1  copy of mem_rsp_error
- dBus_rsp_data  out  32  aligned, zero-extended read data
- mem_cmd_valid / mem_cmd_ready  out / in  1  memory command handshake
- mem_cmd_wr  out  1  1 = write
- mem_cmd_addr  out  ADDR_W  word-aligned address; bits [1:0] forced to 0
- mem_cmd_mask  out  4  byte enables
- mem_cmd_wdata  out  32  lane-replicated write data
- mem_rsp_valid  in  1  read response, in order, 1 per read
- mem_rsp_error  in  1  response error
- mem_rsp_rdata  in  32  raw word
- pending_count  out  $clog2(MAX_PENDING)+1  outstanding reads
- rsp_orphan  out  1  sticky: response arrived with nothing pending

## Operation
- **Eligibility.** A request is eligible when its valid is high. A read additionally requires the FIFO to be not full. Fullness is evaluated on the registered count, so a same-cycle pop does not unblock a push. iBus requests are always reads. dBus writes are eligible regardless of FIFO state.
- **Arbitration.** With one eligible request, that request wins.
  - With both eligible and PRIO_MODE = 0, the winner is the bus that did not win the last accepted command (last_grant register).
  - With both eligible and PRIO_MODE = 1, dBus wins.
- **Grant lock.** Once mem_cmd_valid is high and mem_cmd_ready is low, the grant and all mem_cmd_* fields hold until acceptance. A newly eligible higher-priority request cannot preempt it.
- **Ready signals.** The winner's cmd_ready equals mem_cmd_ready. The loser's cmd_ready is 0. mem_cmd_valid is high when any request is eligible or the grant is locked.
- **Byte mask.**
  - size 00: mask = 1 << addr[1:0], wdata = {4{data[7:0]}}.
  - size 01: mask = addr[1] ? 1100 : 0011, wdata = {2{data[15:0]}}.
  - Word: mask = 1111. Reads also drive the mask.
- **Read tracking.** On an accepted read, push {src, size, addr[1:0]}. Writes push nothing and produce no response.
- **Response routing.** On mem_rsp_valid with the FIFO non-empty, pop the head entry and strobe the matching bus's rsp valid for one cycle.
  - Data = rdata >> (8 × addr[1:0]) masked to 0xFF for byte, rdata >> (16 × addr[1]) masked to 0xFFFF for half, unmodified for word.
  - The error output is passed through.
- **Orphan response.** mem_rsp_valid with an empty FIFO is dropped: no rsp strobe, and rsp_orphan is set until reset.
- **Simultaneous push and pop.** Both take effect; the count is unchanged. Pointers wrap modulo MAX_PENDING.

## Timing
- Command path is combinational: a memory acceptance in cycle N returns cmd_ready = 1 to the winning master in cycle N.
- Response path is combinational: the rsp strobe occurs in the same cycle as mem_rsp_valid. A response may arrive in the cycle after its command is accepted, but not in the same cycle.
- pending_count and last_grant update on the clock edge following acceptance or pop.
- Reset (asynchronous, any time, including with reads outstanding):
  - FIFO pointers = 0, pending_count = 0, rsp_orphan = 0, lock cleared, last_grant = dBus (so iBus wins the first tie).
  - Rsp valids are 0 because the FIFO is empty.
  - Responses arriving after reset for pre-reset reads are orphans.

## Test plan
- **Round-robin tie.** PRIO_MODE = 0; both buses hold reads at 0x100 (iBus) and 0x204 (dBus), mem_cmd_ready = 1. Required: mem_cmd_addr order 0x100, 0x204, 0x100 and so on. Responses 0xAABBCCDD, 0x11223344 land on iBus, then dBus, in order.
- **Byte and half reads.** dBus byte read at 0x3, rdata 0xAABBCCDD -> dBus_rsp_data = 0x000000AA, mask 1000. Half read at 0x2 -> 0x0000AABB, mask 1100.
- **Byte write.** Write byte 0x5A at 0x11 -> mem_cmd_addr 0x10, mask 0010, wdata 0x5A5A5A5A, no response generated, pending_count stays 0.
- **FIFO full and grant lock.** MAX_PENDING = 4; issue 4 reads with no responses -> read ready low, pending_count = 4, while a dBus write is still accepted. Separately, hold mem_cmd_ready = 0 -> mem_cmd_* stable and the grant unchanged for 5 cycles.
- **Priority and simultaneous push/pop.** PRIO_MODE = 1 with both buses valid -> dBus always wins. A push and a pop in the same cycle at count 2 -> count stays 2.
- **Reset and orphan.** Assert reset with 3 reads pending, then deliver mem_rsp_valid -> no rsp strobe, rsp_orphan = 1.

Source files
------------

// File: rtl/membus_arbiter.sv
// Two-master (iBus/dBus) arbiter onto a single-port memory bus with an
// in-order outstanding-read tag FIFO that steers responses back to their issuer.
module membus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int MAX_PENDING = 4,
    parameter int PRIO_MODE   = 0
) (
    input  logic                          clk_cpu,
    input  logic                          clk_cpu_reset_,
    input  logic                          iBus_cmd_valid,
    output logic                          iBus_cmd_ready,
    input  logic [ADDR_W-1:0]             iBus_cmd_payload_pc,
    output logic                          iBus_rsp_valid,
    output logic                          iBus_rsp_payload_error,
    output logic [31:0]                   iBus_rsp_payload_inst,
    input  logic                          dBus_cmd_valid,
    output logic                          dBus_cmd_ready,
    input  logic                          dBus_cmd_payload_wr,
    input  logic [ADDR_W-1:0]             dBus_cmd_payload_address,
    input  logic [31:0]                   dBus_cmd_payload_data,
    input  logic [1:0]                    dBus_cmd_payload_size,
    output logic                          dBus_rsp_ready,
    output logic                          dBus_rsp_error,
    output logic [31:0]                   dBus_rsp_data,
    output logic                          mem_cmd_valid,
    input  logic                          mem_cmd_ready,
    output logic                          mem_cmd_wr,
    output logic [ADDR_W-1:0]             mem_cmd_addr,
    output logic [3:0]                    mem_cmd_mask,
    output logic [31:0]                   mem_cmd_wdata,
    input  logic                          mem_rsp_valid,
    input  logic                          mem_rsp_error,
    input  logic [31:0]                   mem_rsp_rdata,
    output logic [$clog2(MAX_PENDING):0]  pending_count,
    output logic                          rsp_orphan
);

    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_PENDING);
    localparam logic SRC_I = 1'b0;
    localparam logic SRC_D = 1'b1;

    function automatic logic [3:0] f_mask(input logic [1:0] size, input logic [1:0] lsb);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << lsb;
            2'b01:   m = lsb[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] f_rdata(input logic [1:0] size, input logic [1:0] lsb,
                                            input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] res;
        sh  = 32'd0;
        res = rd;
        case (size)
            2'b00: begin
                sh  = rd >> {lsb, 3'b000};
                res = {24'd0, sh[7:0]};
            end
            2'b01: begin
                sh  = rd >> {lsb[1], 4'b0000};
                res = {16'd0, sh[15:0]};
            end
            default: res = rd;
        endcase
        return res;
    endfunction

    logic               r_lock;
    logic               r_lock_src;
    logic               r_lock_wr;
    logic [ADDR_W-1:0]  r_lock_addr;
    logic [31:0]        r_lock_data;
    logic [1:0]         r_lock_size;
    logic               r_last_grant;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_orphan;
    logic [4:0]         r_fifo [MAX_PENDING];

    logic               w_full;
    logic               w_i_elig;
    logic               w_d_elig;
    logic               w_arb_src;
    logic               w_sel_src;
    logic               w_sel_wr;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [31:0]        w_sel_data;
    logic [1:0]         w_sel_size;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [4:0]         w_head;

    // Full is judged on the registered count so a same-cycle pop never unblocks a read.
    assign w_full   = (r_count == FULL_CNT);
    assign w_i_elig = iBus_cmd_valid && !w_full;
    assign w_d_elig = dBus_cmd_valid && (dBus_cmd_payload_wr || !w_full);

    // Winner among eligible requests when no grant is locked.
    always_comb begin
        w_arb_src = SRC_I;
        if (w_i_elig && w_d_elig) begin
            if (PRIO_MODE == 1) begin
                w_arb_src = SRC_D;
            end else begin
                w_arb_src = ~r_last_grant;
            end
        end else if (w_d_elig) begin
            w_arb_src = SRC_D;
        end else begin
            w_arb_src = SRC_I;
        end
    end

    // Command fields come from the locked copy while a stalled command waits.
    always_comb begin
        w_sel_src  = SRC_I;
        w_sel_wr   = 1'b0;
        w_sel_addr = iBus_cmd_payload_pc;
        w_sel_data = 32'd0;
        w_sel_size = 2'b10;
        if (r_lock) begin
            w_sel_src  = r_lock_src;
            w_sel_wr   = r_lock_wr;
            w_sel_addr = r_lock_addr;
            w_sel_data = r_lock_data;
            w_sel_size = r_lock_size;
        end else if (w_arb_src == SRC_D) begin
            w_sel_src  = SRC_D;
            w_sel_wr   = dBus_cmd_payload_wr;
            w_sel_addr = dBus_cmd_payload_address;
            w_sel_data = dBus_cmd_payload_data;
            w_sel_size = dBus_cmd_payload_size;
        end else begin
            w_sel_src  = SRC_I;
            w_sel_wr   = 1'b0;
            w_sel_addr = iBus_cmd_payload_pc;
            w_sel_data = 32'd0;
            w_sel_size = 2'b10;
        end
    end

    assign mem_cmd_valid  = r_lock || w_i_elig || w_d_elig;
    assign mem_cmd_wr     = w_sel_wr;
    assign mem_cmd_addr   = {w_sel_addr[ADDR_W-1:2], 2'b00};
    assign mem_cmd_mask   = f_mask(w_sel_size, w_sel_addr[1:0]);
    assign mem_cmd_wdata  = f_wdata(w_sel_size, w_sel_data);
    assign w_accept       = mem_cmd_valid && mem_cmd_ready;
    assign iBus_cmd_ready = mem_cmd_valid && (w_sel_src == SRC_I) && mem_cmd_ready;
    assign dBus_cmd_ready = mem_cmd_valid && (w_sel_src == SRC_D) && mem_cmd_ready;

    assign w_push = w_accept && !w_sel_wr;
    assign w_pop  = mem_rsp_valid && (r_count != {CNT_W{1'b0}});
    assign w_head = r_fifo[r_rd_ptr];

    assign iBus_rsp_valid         = w_pop && (w_head[4] == SRC_I);
    assign iBus_rsp_payload_error = mem_rsp_error;
    assign iBus_rsp_payload_inst  = mem_rsp_rdata;
    assign dBus_rsp_ready         = w_pop && (w_head[4] == SRC_D);
    assign dBus_rsp_error         = mem_rsp_error;
    assign dBus_rsp_data          = f_rdata(w_head[3:2], w_head[1:0], mem_rsp_rdata);
    assign pending_count          = r_count;
    assign rsp_orphan             = r_orphan;

    // Capture the presented command when memory stalls it; release on acceptance.
    always_ff @(posedge clk_cpu or negedge clk_cpu_reset_) begin
        if (!clk_cpu_reset_) begin
            r_lock      <= 1'b0;
            r_lock_src  <= SRC_I;
            r_lock_wr   <= 1'b0;
            r_lock_addr <= {ADDR_W{1'b0}};
            r_lock_data <= 32'd0;
            r_lock_size <= 2'b00;
        end else if (mem_cmd_valid && !mem_cmd_ready) begin
            r_lock      <= 1'b1;
            r_lock_src  <= w_sel_src;
            r_lock_wr   <= w_sel_wr;
            r_lock_addr <= w_sel_addr;
            r_lock_data <= w_sel_data;
            r_lock_size <= w_sel_size;
        end else begin
            r_lock      <= 1'b0;
        end
    end

    // Round-robin history; reset to dBus so iBus wins the first tie.
    always_ff @(posedge clk_cpu or negedge clk_cpu_reset_) begin
        if (!clk_cpu_reset_) begin
            r_last_grant <= SRC_D;
        end else if (w_accept) begin
            r_last_grant <= w_sel_src;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

    // FIFO pointers, occupancy and the sticky orphan flag.
    always_ff @(posedge clk_cpu or negedge clk_cpu_reset_) begin
        if (!clk_cpu_reset_) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            r_orphan <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (mem_rsp_valid && (r_count == {CNT_W{1'b0}})) begin
                r_orphan <= 1'b1;
            end
        end
    end

    // Tag storage: {source, size, byte offset} per outstanding read.
    always_ff @(posedge clk_cpu) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {w_sel_src, w_sel_size, w_sel_addr[1:0]};
        end
    end

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench: expected commands/responses are queued with the stimulus and
// a negedge monitor compares them whenever the round-robin instance presents one.
module tb_membus_arbiter;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, d_valid, d_wr, m_ready, r_valid, r_err;
    logic [31:0] i_pc, d_addr, d_data, r_data;
    logic [1:0]  d_size;

    logic        a_icr, a_irv, a_ierr, a_dcr, a_drv, a_derr, a_mv, a_mwr, a_orph;
    logic [31:0] a_iinst, a_ddata, a_maddr, a_mwdata;
    logic [3:0]  a_mmask;
    logic [2:0]  a_pend;
    logic        p_icr, p_irv, p_ierr, p_dcr, p_drv, p_derr, p_mv, p_mwr, p_orph;
    logic [31:0] p_iinst, p_ddata, p_maddr, p_mwdata;
    logic [3:0]  p_mmask;
    logic [2:0]  p_pend;

    int   n_tests = 0;
    int   n_fail  = 0;
    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    cmd_t mon_c;
    rsp_t mon_r;

    always #5 clk = ~clk;

    membus_arbiter #(.ADDR_W(32), .MAX_PENDING(4), .PRIO_MODE(0)) u_rr (
        .clk_cpu(clk), .clk_cpu_reset_(rst_n),
        .iBus_cmd_valid(i_valid), .iBus_cmd_ready(a_icr), .iBus_cmd_payload_pc(i_pc),
        .iBus_rsp_valid(a_irv), .iBus_rsp_payload_error(a_ierr), .iBus_rsp_payload_inst(a_iinst),
        .dBus_cmd_valid(d_valid), .dBus_cmd_ready(a_dcr), .dBus_cmd_payload_wr(d_wr),
        .dBus_cmd_payload_address(d_addr), .dBus_cmd_payload_data(d_data),
        .dBus_cmd_payload_size(d_size), .dBus_rsp_ready(a_drv), .dBus_rsp_error(a_derr),
        .dBus_rsp_data(a_ddata), .mem_cmd_valid(a_mv), .mem_cmd_ready(m_ready),
        .mem_cmd_wr(a_mwr), .mem_cmd_addr(a_maddr), .mem_cmd_mask(a_mmask),
        .mem_cmd_wdata(a_mwdata), .mem_rsp_valid(r_valid), .mem_rsp_error(r_err),
        .mem_rsp_rdata(r_data), .pending_count(a_pend), .rsp_orphan(a_orph)
    );

    membus_arbiter #(.ADDR_W(32), .MAX_PENDING(4), .PRIO_MODE(1)) u_pr (
        .clk_cpu(clk), .clk_cpu_reset_(rst_n),
        .iBus_cmd_valid(i_valid), .iBus_cmd_ready(p_icr), .iBus_cmd_payload_pc(i_pc),
        .iBus_rsp_valid(p_irv), .iBus_rsp_payload_error(p_ierr), .iBus_rsp_payload_inst(p_iinst),
        .dBus_cmd_valid(d_valid), .dBus_cmd_ready(p_dcr), .dBus_cmd_payload_wr(d_wr),
        .dBus_cmd_payload_address(d_addr), .dBus_cmd_payload_data(d_data),
        .dBus_cmd_payload_size(d_size), .dBus_rsp_ready(p_drv), .dBus_rsp_error(p_derr),
        .dBus_rsp_data(p_ddata), .mem_cmd_valid(p_mv), .mem_cmd_ready(m_ready),
        .mem_cmd_wr(p_mwr), .mem_cmd_addr(p_maddr), .mem_cmd_mask(p_mmask),
        .mem_cmd_wdata(p_mwdata), .mem_rsp_valid(r_valid), .mem_rsp_error(r_err),
        .mem_rsp_rdata(r_data), .pending_count(p_pend), .rsp_orphan(p_orph)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic exp_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] mask,
                           input logic [31:0] wdata);
        cmd_q.push_back('{wr: wr, addr: addr, mask: mask, wdata: wdata});
    endtask

    task automatic exp_rsp(input logic is_d, input logic [31:0] data, input logic err);
        rsp_q.push_back('{is_d: is_d, data: data, err: err});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic dcmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] size);
        d_valid = 1'b1; d_wr = wr; d_addr = addr; d_data = data; d_size = size;
        m_ready = 1'b1;
        cyc();
        d_valid = 1'b0; d_wr = 1'b0; d_data = 32'd0;
    endtask

    task automatic rsp(input logic [31:0] data, input logic err);
        r_valid = 1'b1; r_data = data; r_err = err;
        cyc();
        r_valid = 1'b0; r_err = 1'b0;
    endtask

    // Scoreboard monitor for the round-robin instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_mv && m_ready) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected_cmd", a_maddr, 32'hFFFF_FFFF);
                end else begin
                    mon_c = cmd_q.pop_front();
                    chk("cmd_addr", a_maddr, mon_c.addr);
                    chk("cmd_wr", {31'd0, a_mwr}, {31'd0, mon_c.wr});
                    chk("cmd_mask", {28'd0, a_mmask}, {28'd0, mon_c.mask});
                    chk("cmd_wdata", a_mwdata, mon_c.wdata);
                end
            end
            if (a_irv || a_drv) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", {30'd0, a_irv, a_drv}, 32'd0);
                end else begin
                    mon_r = rsp_q.pop_front();
                    chk("rsp_bus", {30'd0, a_irv, a_drv}, mon_r.is_d ? 32'd1 : 32'd2);
                    chk("rsp_data", mon_r.is_d ? a_ddata : a_iinst, mon_r.data);
                    chk("rsp_err", {31'd0, mon_r.is_d ? a_derr : a_ierr}, {31'd0, mon_r.err});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_pc = 32'd0; d_valid = 1'b0; d_wr = 1'b0;
        d_addr = 32'd0; d_data = 32'd0; d_size = 2'b10; m_ready = 1'b0;
        r_valid = 1'b0; r_err = 1'b0; r_data = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pending", {29'd0, a_pend}, 32'd0);
        chk("rst_orphan", {31'd0, a_orph}, 32'd0);
        chk("rst_cmd_valid", {31'd0, a_mv}, 32'd0);
        chk("rst_rsp_valid", {30'd0, a_irv, a_drv}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Round-robin tie: four reads fill the FIFO.
        exp_cmd(1'b0, 32'h100, 4'hF, 32'd0); exp_cmd(1'b0, 32'h204, 4'hF, 32'd0);
        exp_cmd(1'b0, 32'h100, 4'hF, 32'd0); exp_cmd(1'b0, 32'h204, 4'hF, 32'd0);
        exp_rsp(1'b0, 32'hAABBCCDD, 1'b0); exp_rsp(1'b1, 32'h11223344, 1'b0);
        exp_rsp(1'b0, 32'h01020304, 1'b1); exp_rsp(1'b1, 32'h0A0B0C0D, 1'b0);
        i_valid = 1'b1; i_pc = 32'h100;
        d_valid = 1'b1; d_wr = 1'b0; d_addr = 32'h204; d_size = 2'b10; d_data = 32'd0;
        m_ready = 1'b1;
        repeat (4) cyc();
        // Full FIFO: iBus read blocked, dBus write still accepted.
        i_pc = 32'h300; d_wr = 1'b1; d_addr = 32'h40; d_data = 32'h12345678;
        exp_cmd(1'b1, 32'h40, 4'hF, 32'h12345678);
        @(negedge clk);
        chk("full_pending", {29'd0, a_pend}, 32'd4);
        chk("full_iready", {31'd0, a_icr}, 32'd0);
        chk("full_dwr_ready", {31'd0, a_dcr}, 32'd1);
        cyc();
        i_valid = 1'b0; d_valid = 1'b0; d_wr = 1'b0; d_data = 32'd0;
        @(negedge clk);
        chk("wr_no_push", {29'd0, a_pend}, 32'd4);
        cyc();
        rsp(32'hAABBCCDD, 1'b0); rsp(32'h11223344, 1'b0);
        rsp(32'h01020304, 1'b1); rsp(32'h0A0B0C0D, 1'b0);
        @(negedge clk);
        chk("drain_pending", {29'd0, a_pend}, 32'd0);
        cyc();

        // Sub-word reads.
        exp_cmd(1'b0, 32'h0, 4'b1000, 32'd0); exp_rsp(1'b1, 32'h000000AA, 1'b0);
        dcmd(1'b0, 32'h3, 32'd0, 2'b00); rsp(32'hAABBCCDD, 1'b0);
        exp_cmd(1'b0, 32'h0, 4'b1100, 32'd0); exp_rsp(1'b1, 32'h0000AABB, 1'b0);
        dcmd(1'b0, 32'h2, 32'd0, 2'b01); rsp(32'hAABBCCDD, 1'b0);
        exp_cmd(1'b0, 32'h0, 4'b0010, 32'd0); exp_rsp(1'b1, 32'h000000CC, 1'b0);
        dcmd(1'b0, 32'h1, 32'd0, 2'b00); rsp(32'hAABBCCDD, 1'b0);
        exp_cmd(1'b0, 32'h0, 4'b0011, 32'd0); exp_rsp(1'b1, 32'h0000CCDD, 1'b0);
        dcmd(1'b0, 32'h0, 32'd0, 2'b01); rsp(32'hAABBCCDD, 1'b0);

        // Sub-word writes produce no response.
        exp_cmd(1'b1, 32'h10, 4'b0010, 32'h5A5A5A5A);
        dcmd(1'b1, 32'h11, 32'h0000005A, 2'b00);
        @(negedge clk);
        chk("bytewr_pending", {29'd0, a_pend}, 32'd0);
        cyc();
        exp_cmd(1'b1, 32'h20, 4'b1100, 32'hBEEFBEEF);
        dcmd(1'b1, 32'h22, 32'h0000BEEF, 2'b01);

        // Grant lock: stalled dBus read must not be preempted by iBus.
        exp_cmd(1'b0, 32'h80, 4'hF, 32'd0); exp_cmd(1'b0, 32'h500, 4'hF, 32'd0);
        exp_rsp(1'b1, 32'hCAFEF00D, 1'b0); exp_rsp(1'b0, 32'h0BADC0DE, 1'b0);
        m_ready = 1'b0;
        d_valid = 1'b1; d_wr = 1'b0; d_addr = 32'h80; d_size = 2'b10; d_data = 32'd0;
        cyc();
        i_valid = 1'b1; i_pc = 32'h500;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("lock_addr", a_maddr, 32'h80);
            chk("lock_valid", {31'd0, a_mv}, 32'd1);
            chk("lock_readies", {30'd0, a_icr, a_dcr}, 32'd0);
            cyc();
        end
        m_ready = 1'b1;
        @(negedge clk);
        chk("lock_release", {30'd0, a_icr, a_dcr}, 32'd1);
        cyc();
        d_valid = 1'b0;
        @(negedge clk);
        chk("after_lock_iready", {30'd0, a_icr, a_dcr}, 32'd2);
        cyc();
        i_valid = 1'b0;
        rsp(32'hCAFEF00D, 1'b0); rsp(32'h0BADC0DE, 1'b0);

        // Simultaneous push and pop at count 2.
        exp_cmd(1'b0, 32'h0, 4'hF, 32'd0); exp_cmd(1'b0, 32'h4, 4'hF, 32'd0);
        exp_cmd(1'b0, 32'h8, 4'hF, 32'd0);
        exp_rsp(1'b1, 32'h11110000, 1'b0); exp_rsp(1'b1, 32'h22220000, 1'b0);
        exp_rsp(1'b1, 32'h33330000, 1'b0);
        dcmd(1'b0, 32'h0, 32'd0, 2'b10); dcmd(1'b0, 32'h4, 32'd0, 2'b10);
        @(negedge clk);
        chk("pp_before", {29'd0, a_pend}, 32'd2);
        cyc();
        d_valid = 1'b1; d_wr = 1'b0; d_addr = 32'h8; d_size = 2'b10;
        r_valid = 1'b1; r_data = 32'h11110000;
        cyc();
        d_valid = 1'b0; r_valid = 1'b0;
        @(negedge clk);
        chk("pp_after", {29'd0, a_pend}, 32'd2);
        cyc();
        rsp(32'h22220000, 1'b0); rsp(32'h33330000, 1'b0);
        @(negedge clk);
        chk("pp_drain", {29'd0, a_pend}, 32'd0);
        cyc();

        // Fixed priority instance; round-robin instance alternates on the same inputs.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        exp_cmd(1'b0, 32'h100, 4'hF, 32'd0); exp_cmd(1'b0, 32'h204, 4'hF, 32'd0);
        exp_cmd(1'b0, 32'h100, 4'hF, 32'd0);
        i_valid = 1'b1; i_pc = 32'h100;
        d_valid = 1'b1; d_wr = 1'b0; d_addr = 32'h204; d_size = 2'b10;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("prio_addr", p_maddr, 32'h204);
            chk("prio_readies", {30'd0, p_icr, p_dcr}, 32'd1);
            cyc();
        end
        i_valid = 1'b0; d_valid = 1'b0;
        @(negedge clk);
        chk("rr_pending3", {29'd0, a_pend}, 32'd3);
        chk("prio_pending3", {29'd0, p_pend}, 32'd3);

        // Asynchronous reset with reads outstanding, then an orphan response.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pending", {29'd0, a_pend}, 32'd0);
        chk("async_rst_orphan", {31'd0, a_orph}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        r_valid = 1'b1; r_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("orphan_no_strobe", {30'd0, a_irv, a_drv}, 32'd0);
        chk("orphan_no_strobe_p", {30'd0, p_irv, p_drv}, 32'd0);
        cyc();
        r_valid = 1'b0;
        @(negedge clk);
        chk("orphan_set", {31'd0, a_orph}, 32'd1);
        chk("orphan_set_p", {31'd0, p_orph}, 32'd1);
        cyc();
        @(negedge clk);
        chk("orphan_sticky", {31'd0, a_orph}, 32'd1);
        chk("orphan_pending", {29'd0, a_pend}, 32'd0);
        chk("cmd_q_empty", cmd_q.size(), 32'd0);
        chk("rsp_q_empty", rsp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
